// File: rtl/strip_read_arbiter.sv
// strip_read_arbiter: round-robin sharing of one BRAM read port among strip drivers.
// Build option: define ARB_FIXED_PRIORITY_EN to make the lowest index win instead of round-robin.
// One read is in flight at a time. The cycle after a response, the port just served sits out
// one arbitration so that a request about to drop is not granted again.
module strip_read_arbiter #(
    parameter int NUM_PORTS     = 8,
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 8,
    parameter int READ_LATENCY  = 1
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [NUM_PORTS-1:0]                 req,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]   addr,
    output logic [NUM_PORTS-1:0]                 rdy,
    output logic [DATA_WIDTH-1:0]                data,
    output logic                                 mem_re,
    output logic [ADDRESS_WIDTH-1:0]             mem_raddr,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic [$clog2(NUM_PORTS)-1:0]         grant_idx
);
    localparam int IW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t                   state, state_d;
    logic [IW-1:0]            rr_ptr, rr_ptr_d, pick, grant_idx_d;
    logic [IW:0]              scan;
    logic [1:0]               lat_cnt, lat_cnt_d;
    logic                     mask_vld, mask_vld_d;
    logic [NUM_PORTS-1:0]     elig, rdy_d;
    logic                     found, read_done, mem_re_d;
    logic [DATA_WIDTH-1:0]    data_d;
    logic [ADDRESS_WIDTH-1:0] mem_raddr_d;

    // Requests still allowed to compete: the port served last is hidden for one IDLE cycle.
    always_comb begin
        elig      = req & ~({{(NUM_PORTS-1){1'b0}}, mask_vld} << grant_idx);
        read_done = (state == READ) && (lat_cnt == 2'(READ_LATENCY));
    end

    // Scan from rr_ptr upward with wrap; walking backwards lets the nearest hit win.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan >= (IW+1)'(NUM_PORTS))
                scan = scan - (IW+1)'(NUM_PORTS);
            if (elig[scan[IW-1:0]]) begin
                found = 1'b1;
                pick  = scan[IW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next state: IDLE -> READ on a grant, READ -> RESP when the data is due, RESP -> IDLE.
    always_comb begin
        state_d = (state == IDLE && found) ? READ :
                  read_done                ? RESP :
                  (state == RESP)          ? IDLE : state;
    end

    // Next values of the registered outputs and arbitration bookkeeping.
    always_comb begin
        grant_idx_d = (state == IDLE && found) ? pick : grant_idx;
        mem_raddr_d = (state == IDLE && found) ? addr[pick*ADDRESS_WIDTH +: ADDRESS_WIDTH] : mem_raddr;
        mem_re_d    = (state == IDLE) ? found : (state == READ) ? !read_done : 1'b0;
        lat_cnt_d   = (state == READ) ? lat_cnt + 2'd1 : 2'd0;
        data_d      = read_done ? mem_rdata : data;
        rdy_d       = read_done ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_idx) : '0;
        mask_vld_d  = (state == RESP) ? 1'b1 : (state == IDLE) ? 1'b0 : mask_vld;
`ifdef ARB_FIXED_PRIORITY_EN
        rr_ptr_d    = '0;
`else
        rr_ptr_d    = (state != RESP)                  ? rr_ptr :
                      (grant_idx == IW'(NUM_PORTS-1))  ? '0 : grant_idx + IW'(1);
`endif
    end

    // Output and bookkeeping registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_idx <= '0;
            mem_raddr <= '0;
            mem_re    <= 1'b0;
            lat_cnt   <= 2'd0;
            data      <= '0;
            rdy       <= '0;
            mask_vld  <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            grant_idx <= grant_idx_d;
            mem_raddr <= mem_raddr_d;
            mem_re    <= mem_re_d;
            lat_cnt   <= lat_cnt_d;
            data      <= data_d;
            rdy       <= rdy_d;
            mask_vld  <= mask_vld_d;
            rr_ptr    <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_strip_read_arbiter.sv
// tb_strip_read_arbiter: directed scoreboard bench for strip_read_arbiter with a 1-cycle BRAM model.
module tb_strip_read_arbiter;
    localparam int N  = 8;
    localparam int AW = 13;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0]  rdy;
    logic [7:0]    data;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic [2:0]    grant_idx;

    logic [7:0]    mem [0:8191];
    exp_t          sb [$];
    int            checks = 0;
    int            errors = 0;
    int            n;

    strip_read_arbiter dut (
        .clk(clk), .resetn(resetn), .req(req), .addr(addr), .rdy(rdy), .data(data),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_raddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        addr[p*AW +: AW] = a;
    endtask

    task automatic push_exp(input int p);
        exp_t e;
        e.r = 8'(1 << p);
        e.d = mem[addr[p*AW +: AW]];
        sb.push_back(e);
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rdy == '0 && cyc < 20);
    endtask

    task automatic take(input string tag);
        exp_t e;
        chk({tag, "_queued"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rdy"}, 32'(rdy), 32'(e.r));
            chk({tag, "_data"}, 32'(data), 32'(e.d));
        end
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 8'(a * 7 + (a >> 8));
        mem[13'h0384] = 8'hA5;
        for (int p = 0; p < N; p++) set_addr(p, 13'(p * 256 + 16 + p));
        req = '1;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_raddr", 32'(mem_raddr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_grant", 32'(grant_idx), 0);

        push_exp(0);
`ifndef ARB_FIXED_PRIORITY_EN
        for (int p = 1; p <= N; p++) push_exp(p % N);
`endif
        resetn = 1'b1;
        wait_rdy(n);
        chk("first_lat", 32'(n), 3);
        take("first");
`ifndef ARB_FIXED_PRIORITY_EN
        for (int i = 1; i <= N; i++) begin
            wait_rdy(n);
            chk($sformatf("all_gap%0d", i), 32'(n), 4);
            take($sformatf("all%0d", i));
        end
`endif
        req = '0;
        repeat (2) @(negedge clk);
        chk("idle_rdy", 32'(rdy), 0);
        chk("idle_mem_re", 32'(mem_re), 0);

        set_addr(3, 13'h0384);
        req = 8'h08;
        push_exp(3);
        @(negedge clk);
        chk("single_raddr", 32'(mem_raddr), 32'h384);
        chk("single_re", 32'(mem_re), 1);
        chk("single_grant", 32'(grant_idx), 3);
        @(negedge clk);
        chk("single_t2_rdy", 32'(rdy), 0);
        @(negedge clk);
        take("single");
        req = '0;
        @(negedge clk);
        chk("single_t4_rdy", 32'(rdy), 0);

        set_addr(1, 13'h0222);
        req = 8'h02;
        push_exp(1);
        @(negedge clk);
        set_addr(1, 13'h1555);
        req = '0;
        wait_rdy(n);
        chk("drop_lat", 32'(n), 2);
        take("drop_during_read");
        repeat (2) @(negedge clk);

`ifndef ARB_FIXED_PRIORITY_EN
        set_addr(6, 13'h0666);
        req = 8'h40;
        push_exp(6);
        wait_rdy(n);
        take("pre_wrap");
        req = '0;
        @(negedge clk);
        req = 8'h81;
        push_exp(7);
        push_exp(0);
        wait_rdy(n);
        take("wrap_first");
        req = 8'h01;
        wait_rdy(n);
        chk("wrap_gap", 32'(n), 4);
        take("wrap_second");
        req = '0;
        repeat (2) @(negedge clk);

        set_addr(5, 13'h0555);
        req = 8'h20;
        @(negedge clk);
        chk("abort_re", 32'(mem_re), 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_rdy", 32'(rdy), 0);
        chk("abort_mem_re", 32'(mem_re), 0);
        chk("abort_raddr", 32'(mem_raddr), 0);
        set_addr(0, 13'h0ABC);
        req = 8'h21;
        push_exp(0);
        push_exp(5);
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_grant", 32'(grant_idx), 0);
        chk("abort_new_raddr", 32'(mem_raddr), 32'h0ABC);
        wait_rdy(n);
        chk("abort_lat", 32'(n), 2);
        take("abort_port0");
        req = 8'h20;
        wait_rdy(n);
        chk("abort_gap", 32'(n), 4);
        take("abort_port5");
        req = '0;
`else
        set_addr(0, 13'h0ABC);
        set_addr(5, 13'h0555);
        req = 8'h21;
        for (int i = 0; i < 6; i++) push_exp((i % 2) ? 5 : 0);
        for (int i = 0; i < 6; i++) begin
            wait_rdy(n);
            if (i > 0) chk($sformatf("fixed_gap%0d", i), 32'(n), 4);
            take($sformatf("fixed%0d", i));
        end
        req = '0;
`endif
        repeat (3) @(negedge clk);
        chk("end_rdy", 32'(rdy), 0);
        chk("end_queue_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
